// File: rtl/seg_shift_out_if.sv
// -----------------------------------------------------------------------------
// seg_shift_out_if
// Control/handshake bundle between the segment-map stage and seg_shift_out.
//   start     : request to shift out par_data (sampled only while idle)
//   auto_rfsh : restart automatically after every done pulse
//   par_data  : DATA_W-bit segment pattern, MSB sent first
//   busy      : transfer in progress (capture cycle through last latch cycle)
//   done      : one-cycle completion pulse
// master = producer of the pattern, slave = seg_shift_out.
// -----------------------------------------------------------------------------
interface seg_shift_out_if #(
  parameter int DATA_W = 64
);
  logic              start;
  logic              auto_rfsh;
  logic [DATA_W-1:0] par_data;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output auto_rfsh,
    output par_data,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  auto_rfsh,
    input  par_data,
    output busy,
    output done
  );
endinterface

// File: rtl/seg_shift_out.sv
// -----------------------------------------------------------------------------
// seg_shift_out
// Shifts a DATA_W-bit segment pattern MSB-first into an external shift-register
// chain, then strobes the latch/output enable.
//   clk, rst_n : system clock, asynchronous active-low reset
//   ctrl       : seg_shift_out_if.slave (start, auto_rfsh, par_data, busy, done)
//   s_clk      : serial clock, low for CLK_DIV cycles then high for CLK_DIV
//   s_dat      : serial data, constant over a whole bit period
//   s_en       : latch strobe, high for CLK_DIV cycles after the last bit
//   s_clr_n    : active-low chain clear, low only while in / just out of reset
// Latency from the start-sampling edge to done is 1+(2*DATA_W+1)*CLK_DIV.
// -----------------------------------------------------------------------------
module seg_shift_out #(
  parameter int DATA_W  = 64,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_shift_out_if.slave   ctrl,
  output logic             s_clk,
  output logic             s_dat,
  output logic             s_en,
  output logic             s_clr_n
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LATCH
  } state_t;

  // 2*255-1 fits in 9 bits, covering the whole legal CLK_DIV range.
  localparam int DIV_W = 9;
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [DIV_W-1:0] PERIOD_LAST = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CLK_RISE    = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic              accept;

  assign shreg_next = shreg << 1;

  // s_clr_n doubles as the "one edge since reset" flag, so start is only
  // honoured from the second edge after rst_n rises. A done pulse with
  // auto_rfsh behaves exactly like a start in the same cycle.
  assign accept = s_clr_n && (ctrl.start || (ctrl.done && ctrl.auto_rfsh));

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      // NOTE: the shift register is reset too, so no stale pattern can ever
      // reach s_dat after an aborted transfer.
      shreg     <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      ctrl.busy <= 1'b0;
      ctrl.done <= 1'b0;
      s_clk     <= 1'b0;
      s_dat     <= 1'b0;
      s_en      <= 1'b0;
      s_clr_n   <= 1'b0;
    end else begin
      s_clr_n   <= 1'b1;
      ctrl.done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= SHIFT;
            shreg     <= ctrl.par_data;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            ctrl.busy <= 1'b1;
            s_clk     <= 1'b0;
            s_dat     <= ctrl.par_data[DATA_W-1];
          end
        end

        SHIFT: begin
          if (div_cnt == PERIOD_LAST) begin
            // End of a bit period: advance to the next bit (or to LATCH).
            div_cnt <= '0;
            shreg   <= shreg_next;
            s_clk   <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state <= LATCH;
              s_dat <= 1'b0;
              s_en  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              s_dat   <= shreg_next[DATA_W-1];
            end
          end else begin
            // s_clk is registered, so decide on the count the next cycle
            // will carry: high once it reaches CLK_DIV.
            div_cnt <= div_cnt + 1'b1;
            s_clk   <= (div_cnt >= CLK_RISE);
          end
        end

        LATCH: begin
          if (div_cnt == LATCH_LAST) begin
            state     <= IDLE;
            div_cnt   <= '0;
            ctrl.busy <= 1'b0;
            ctrl.done <= 1'b1;
            s_en      <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_shift_out.sv
// -----------------------------------------------------------------------------
// tb_seg_shift_out
// Two instances: A with defaults (DATA_W=64, CLK_DIV=2) and B with DATA_W=8,
// CLK_DIV=1. Stimulus tasks advance one clock per call and push the expected
// transfer (pattern, done cycle) whenever the reference timeline says the
// request is accepted. Negedge monitors rebuild the serial word from s_dat at
// s_clk rising edges and compare against the queue head on every done pulse.
// Cycle n is the period after the n-th rising clk edge; a start held during
// cycle c yields done in cycle c + 1 + (2*DATA_W+1)*CLK_DIV.
// -----------------------------------------------------------------------------
module tb_seg_shift_out;

  localparam int DW_A  = 64;
  localparam int DIV_A = 2;
  localparam int LAT_A = 1 + (2 * DW_A + 1) * DIV_A;
  localparam int DW_B  = 8;
  localparam int DIV_B = 1;
  localparam int LAT_B = 1 + (2 * DW_B + 1) * DIV_B;
  localparam int NEVER = 1 << 30;

  typedef struct {
    logic [63:0] data;
    int          done_cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rst_b = 1'b0;
  int   cyc   = 0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seg_shift_out_if #(.DATA_W(DW_A)) if_a ();
  seg_shift_out_if #(.DATA_W(DW_B)) if_b ();

  logic sclk_a, sdat_a, sen_a, sclrn_a;
  logic sclk_b, sdat_b, sen_b, sclrn_b;

  seg_shift_out #(.DATA_W(DW_A), .CLK_DIV(DIV_A)) dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .ctrl    (if_a.slave),
    .s_clk   (sclk_a),
    .s_dat   (sdat_a),
    .s_en    (sen_a),
    .s_clr_n (sclrn_a)
  );

  seg_shift_out #(.DATA_W(DW_B), .CLK_DIV(DIV_B)) dut_b (
    .clk     (clk),
    .rst_n   (rst_b),
    .ctrl    (if_b.slave),
    .s_clk   (sclk_b),
    .s_dat   (sdat_b),
    .s_en    (sen_b),
    .s_clr_n (sclrn_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference timeline ----------------
  exp_t q_a[$];
  exp_t q_b[$];
  int   cur_a   = 0;
  bit   cur_a_v = 1'b0;
  int   ready_a = NEVER;
  int   cur_b   = 0;
  bit   cur_b_v = 1'b0;
  int   ready_b = NEVER;

  // A request in cycle c is taken when the block is idle (no transfer, or
  // its done cycle has been reached) and at least one edge has passed since
  // reset release. auto_rfsh counts only in a done cycle.
  task automatic step_a(input logic st, input logic au, input logic [63:0] d);
    bit idle, in_done, acc;
    // NOTE: inputs are driven with blocking assignments away from the edge.
    if_a.start     = st;
    if_a.auto_rfsh = au;
    if_a.par_data  = d;
    idle    = !cur_a_v || (cyc >= cur_a + LAT_A);
    in_done = cur_a_v && (cyc == cur_a + LAT_A);
    acc     = idle && (cyc >= ready_a) && (st || (au && in_done));
    if (acc) begin
      q_a.push_back(exp_t'{data: d, done_cyc: cyc + LAT_A});
      cur_a   = cyc;
      cur_a_v = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a(1'b0, 1'b0, {$urandom(), $urandom()});
  endtask

  task automatic step_b(input logic st, input logic [7:0] d);
    bit idle, acc;
    if_b.start     = st;
    if_b.auto_rfsh = 1'b0;
    if_b.par_data  = d;
    idle = !cur_b_v || (cyc >= cur_b + LAT_B);
    acc  = idle && (cyc >= ready_b) && st;
    if (acc) begin
      q_b.push_back(exp_t'{data: {56'd0, d}, done_cyc: cyc + LAT_B});
      cur_b   = cyc;
      cur_b_v = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor A ----------------
  logic        prev_clk_a = 1'b0, prev_dat_a = 1'b0, prev_en_a = 1'b0;
  logic [63:0] rx_a = '0;
  int          edges_a = 0, en_cnt_a = 0, en_first_a = 0;
  logic        exp_busy_a;
  exp_t        e_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk_a = 1'b0; prev_dat_a = 1'b0; prev_en_a = 1'b0;
      rx_a = '0; edges_a = 0; en_cnt_a = 0; en_first_a = 0;
    end else begin
      exp_busy_a = cur_a_v && (cyc > cur_a) && (cyc < cur_a + LAT_A);
      check("busy_a", if_a.busy, exp_busy_a);
      check("clr_n_a", sclrn_a, cyc >= ready_a);
      if (!exp_busy_a) check("idle_lines_a", {sclk_a, sdat_a, sen_a}, 3'b000);
      if (sclk_a && !prev_clk_a) begin
        check("dat_stable_a", sdat_a, prev_dat_a);
        rx_a = {rx_a[62:0], sdat_a};
        edges_a++;
      end
      if (sen_a && !prev_en_a) en_first_a = cyc;
      if (sen_a) en_cnt_a++;
      if (if_a.done) begin
        check("done_expected_a", q_a.size() != 0, 1'b1);
        if (q_a.size() != 0) begin
          e_a = q_a.pop_front();
          check("done_cycle_a", cyc, e_a.done_cyc);
          check("data_a", rx_a, e_a.data);
          check("sclk_edges_a", edges_a, DW_A);
          check("en_len_a", en_cnt_a, DIV_A);
          check("en_start_a", en_first_a, e_a.done_cyc - DIV_A);
        end
        rx_a = '0; edges_a = 0; en_cnt_a = 0;
      end
      prev_clk_a = sclk_a; prev_dat_a = sdat_a; prev_en_a = sen_a;
    end
  end

  // ---------------- monitor B ----------------
  logic       prev_clk_b = 1'b0, prev_dat_b = 1'b0;
  logic [7:0] rx_b = '0;
  int         edges_b = 0, en_cnt_b = 0;
  logic       exp_busy_b;
  exp_t       e_b;

  always @(negedge clk) begin
    if (!rst_b) begin
      prev_clk_b = 1'b0; prev_dat_b = 1'b0; rx_b = '0; edges_b = 0; en_cnt_b = 0;
    end else begin
      exp_busy_b = cur_b_v && (cyc > cur_b) && (cyc < cur_b + LAT_B);
      check("busy_b", if_b.busy, exp_busy_b);
      check("clr_n_b", sclrn_b, cyc >= ready_b);
      if (!exp_busy_b) check("idle_lines_b", {sclk_b, sdat_b, sen_b}, 3'b000);
      if (sclk_b && !prev_clk_b) begin
        check("dat_stable_b", sdat_b, prev_dat_b);
        rx_b = {rx_b[6:0], sdat_b};
        edges_b++;
      end
      if (sen_b) en_cnt_b++;
      if (if_b.done) begin
        check("done_expected_b", q_b.size() != 0, 1'b1);
        if (q_b.size() != 0) begin
          e_b = q_b.pop_front();
          check("done_cycle_b", cyc, e_b.done_cyc);
          check("data_b", {56'd0, rx_b}, e_b.data);
          check("sclk_edges_b", edges_b, DW_B);
          check("en_len_b", en_cnt_b, DIV_B);
        end
        rx_b = '0; edges_b = 0; en_cnt_b = 0;
      end
      prev_clk_b = sclk_b; prev_dat_b = sdat_b;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    if_a.start = 1'b0; if_a.auto_rfsh = 1'b0; if_a.par_data = '0;
    if_b.start = 1'b0; if_b.auto_rfsh = 1'b0; if_b.par_data = '0;
    repeat (3) @(posedge clk);
    #3;
    check("rst_outs_a", {if_a.busy, if_a.done, sclk_a, sdat_a, sen_a, sclrn_a}, 6'b0);
    check("rst_outs_b", {if_b.busy, if_b.done, sclk_b, sdat_b, sen_b, sclrn_b}, 6'b0);
    rst_n = 1'b1; rst_b = 1'b1;
    ready_a = cyc + 1; ready_b = cyc + 1;

    // B: start on the first edge after release is ignored, then 8'hC3,
    // then a few random bytes.
    step_b(1'b1, 8'h3C);
    step_b(1'b1, 8'hC3);
    for (int i = 0; i < LAT_B + 2; i++) step_b(1'b0, 8'($urandom()));
    for (int t = 0; t < 3; t++) begin
      step_b(1'b1, 8'($urandom()));
      for (int i = 0; i < LAT_B + int'($urandom_range(0, 3)); i++) step_b(1'b0, 8'($urandom()));
    end

    // A: corner pattern, with an ignored start at cycle 100 of the transfer.
    step_a(1'b1, 1'b0, 64'h8000_0000_0000_0001);
    idle_a(99);
    step_a(1'b1, 1'b0, {64{1'b1}});
    idle_a(LAT_A);

    // A: data integrity with par_data forced to all-ones mid-transfer.
    step_a(1'b1, 1'b0, 64'hA5A5_5A5A_0F0F_F0F0);
    for (int i = 0; i < LAT_A + 3; i++) step_a(1'b0, 1'b0, {64{1'b1}});

    // A: start held high -> back-to-back transfers at each done cycle.
    for (int i = 0; i < 2 * LAT_A + 1; i++) step_a(1'b1, 1'b0, {$urandom(), $urandom()});
    idle_a(LAT_A + 5);

    // A: auto refresh, then cleared mid-transfer; must stop after that done.
    step_a(1'b1, 1'b1, {$urandom(), $urandom()});
    for (int i = 0; i < 2 * LAT_A + 100; i++) step_a(1'b0, 1'b1, {$urandom(), $urandom()});
    idle_a(LAT_A + 50);

    // A: random sparse start pulses with random data.
    for (int i = 0; i < 4 * LAT_A; i++)
      step_a($urandom_range(0, 15) == 0, 1'b0, {$urandom(), $urandom()});
    idle_a(LAT_A + 5);

    // A: asynchronous reset at cycle 50 of a transfer, then a fresh transfer.
    step_a(1'b1, 1'b0, {$urandom(), $urandom()});
    idle_a(49);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs_a", {if_a.busy, if_a.done, sclk_a, sdat_a, sen_a, sclrn_a}, 6'b0);
    q_a.delete();
    cur_a_v = 1'b0;
    ready_a = NEVER;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    ready_a = cyc + 1;
    step_a(1'b1, 1'b0, {$urandom(), $urandom()});
    step_a(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF);
    idle_a(LAT_A + 20);

    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
